// File: rtl/serial_mult_sched_pkg.sv
// Shared types for the serial multiplier scheduler.
// Holds the operand width default, FSM states and round-robin pick.
package serial_mult_sched_pkg;

  localparam int W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DONE
  } state_t;

  typedef logic client_t;

  // Lone requester wins; on a tie the client that was not served last wins
  function automatic client_t rr_pick(
    input logic    r0,
    input logic    r1,
    input client_t last
  );
    if (r0 && r1) return ~last;
    return r1 ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/serial_mult_sched_core.sv
// Shift-add accumulator: consumes one multiplier bit per enabled cycle.
// Multiplier bits arrive MSB first, so acc is doubled before each add.
module shift_add_core
  import serial_mult_sched_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           en,
  input  logic           xbit,
  input  logic [W-1:0]   y,
  output logic [2*W-1:0] acc
);

  logic [2*W-1:0] addend;

  assign addend = xbit ? {{W{1'b0}}, y} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= (acc << 1) + addend;
    end
  end

endmodule

// File: rtl/serial_mult_sched.sv
// Two-client round-robin scheduler around the shift-add core.
// Owns the FSM, operand registers and the registered handshakes.
module serial_mult_sched
  import serial_mult_sched_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0,
  input  logic [W-1:0]           x0,
  input  logic [W-1:0]           y0,
  input  logic                   req1,
  input  logic [W-1:0]           x1,
  input  logic [W-1:0]           y1,
  output logic                   ack0,
  output logic                   ack1,
  output logic                   done0,
  output logic                   done1,
  output logic [2*W-1:0]         prod,
  output logic                   busy,
  output logic [$clog2(W+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(W + 1);

  state_t         state;
  client_t        last;
  client_t        owner;
  client_t        win;
  logic [W-1:0]   xreg;
  logic [W-1:0]   yreg;
  logic [2*W-1:0] acc;

  assign win = rr_pick(req0, req1, last);

  shift_add_core #(.W(W)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == CLEAR),
    .en    (state == SHIFT),
    .xbit  (xreg[W-1]),
    .y     (yreg),
    .acc   (acc)
  );

  // done is raised leaving DONE, so the IDLE cycle that follows carries
  // the valid product and may already accept the next job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 1'b1;
      owner   <= 1'b0;
      xreg    <= '0;
      yreg    <= '0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      prod    <= '0;
      busy    <= 1'b0;
      bit_cnt <= '0;
    end else begin
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      unique case (state)
        IDLE: begin
          bit_cnt <= '0;
          busy    <= req0 | req1;
          if (req0 | req1) begin
            owner <= win;
            last  <= win;
            xreg  <= win ? x1 : x0;
            yreg  <= win ? y1 : y0;
            ack0  <= ~win;
            ack1  <= win;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          xreg    <= xreg << 1;
          bit_cnt <= bit_cnt + CW'(1);
          if (bit_cnt == CW'(W - 1)) state <= DONE;
        end
        DONE: begin
          prod  <= acc;
          done0 <= ~owner;
          done1 <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mult_sched.sv
// Directed bench for serial_mult_sched.
// Hand-computed products, latencies and grant order.
module tb_serial_mult_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [5:0]  x0 = '0;
  logic [5:0]  y0 = '0;
  logic [5:0]  x1 = '0;
  logic [5:0]  y1 = '0;
  logic        ack0, ack1, done0, done1, busy;
  logic [11:0] prod;
  logic [2:0]  bit_cnt;

  int total = 0;
  int bad = 0;

  serial_mult_sched dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .x0      (x0),
    .y0      (y0),
    .req1    (req1),
    .x1      (x1),
    .y1      (y1),
    .ack0    (ack0),
    .ack1    (ack1),
    .done0   (done0),
    .done1   (done1),
    .prod    (prod),
    .busy    (busy),
    .bit_cnt (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic job(input int c, input logic [5:0] x, input logic [5:0] y,
                     input logic [11:0] ep, input string tag);
    int n, lat, bc;
    logic a, d, od;
    @(negedge clk);
    if (c == 0) begin x0 = x; y0 = y; req0 = 1'b1; end
    else begin x1 = x; y1 = y; req1 = 1'b1; end
    n = 0; a = 1'b0;
    while (!a && n < 20) begin
      @(negedge clk); n++;
      a = (c == 0) ? ack0 : ack1;
    end
    chk({tag, " ack"}, a, 1);
    chk({tag, " busy@ack"}, busy, 1);
    if (c == 0) req0 = 1'b0; else req1 = 1'b0;
    lat = 0; bc = 1; d = 1'b0; od = 1'b0;
    while (!d && lat < 20) begin
      @(negedge clk); lat++;
      if (busy) bc++;
      d  = (c == 0) ? done0 : done1;
      od = od | ((c == 0) ? done1 : done0);
    end
    chk({tag, " latency"}, lat, 8);
    chk({tag, " prod"}, prod, ep);
    chk({tag, " busy cycles"}, bc, 9);
    chk({tag, " bit_cnt@done"}, bit_cnt, 6);
    chk({tag, " other done"}, od, 0);
    @(negedge clk);
    chk({tag, " busy after"}, busy, 0);
    chk({tag, " bit_cnt idle"}, bit_cnt, 0);
    chk({tag, " prod hold"}, prod, ep);
  endtask

  initial begin
    int n, lat, nd, ng, lastack;
    logic seen;
    logic [11:0] p [8];
    logic        g [8];
    logic        o [8];

    repeat (2) @(negedge clk);
    chk("rst ack0", ack0, 0);
    chk("rst ack1", ack1, 0);
    chk("rst done", {done0, done1}, 0);
    chk("rst busy", busy, 0);
    chk("rst prod", prod, 0);
    chk("rst bit_cnt", bit_cnt, 0);
    rst_n = 1'b1;

    // Tie straight after reset: client 0 first, client 1 at T+9
    @(negedge clk);
    x0 = 6'd5; y0 = 6'd7; x1 = 6'd9; y1 = 6'd3;
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    chk("tie ack0", ack0, 1);
    chk("tie no ack1", ack1, 0);
    req0 = 1'b0;
    lat = 0;
    while (!done0 && lat < 20) begin @(negedge clk); lat++; end
    chk("tie lat0", lat, 8);
    chk("tie prod0", prod, 35);
    chk("tie done1 lo", done1, 0);
    @(negedge clk);
    chk("tie ack1 T+9", ack1, 1);
    req1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 20) begin @(negedge clk); lat++; end
    chk("tie lat1", lat, 8);
    chk("tie prod1", prod, 27);
    @(negedge clk);

    // Both clients hold requests for four jobs
    x0 = 6'd3; y0 = 6'd4; x1 = 6'd5; y1 = 6'd6;
    req0 = 1'b1; req1 = 1'b1;
    nd = 0; ng = 0; n = 0; lastack = 0;
    while (nd < 4 && n < 80) begin
      @(negedge clk); n++;
      if (ack0 | ack1) begin
        chk("fair ack excl", ack0 & ack1, 0);
        if (ng > 0) chk("fair gap", n - lastack, 9);
        lastack = n;
        if (ng < 8) g[ng] = ack1;
        ng++;
      end
      if (done0 | done1) begin
        if (nd < 8) begin p[nd] = prod; o[nd] = done1; end
        nd++;
        if (nd == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    chk("fair jobs", nd, 4);
    chk("fair grants", ng, 4);
    for (int k = 0; k < 4; k++) begin
      chk("fair grant id", g[k], k % 2);
      chk("fair done id", o[k], k % 2);
      chk("fair prod", p[k], (k % 2) ? 30 : 12);
    end
    @(negedge clk);
    chk("fair idle", busy, 0);

    job(0, 6'd13, 6'd11, 12'd143, "single");
    job(0, 6'd0,  6'd63, 12'd0,   "x0");
    job(1, 6'd63, 6'd63, 12'd3969, "max");
    job(0, 6'd1,  6'd1,  12'd1,   "one");

    // req1 pulsed mid-job and withdrawn before IDLE
    @(negedge clk);
    x0 = 6'd2; y0 = 6'd5; req0 = 1'b1;
    @(negedge clk);
    chk("wd ack0", ack0, 1);
    req0 = 1'b0;
    seen = 1'b0; lat = 0;
    while (!done0 && lat < 20) begin
      @(negedge clk); lat++;
      if (lat == 2) begin x1 = 6'd7; y1 = 6'd7; req1 = 1'b1; end
      if (lat == 5) req1 = 1'b0;
      seen = seen | ack1 | done1;
    end
    chk("wd prod", prod, 10);
    repeat (12) begin
      @(negedge clk);
      seen = seen | ack1 | done1 | busy;
    end
    chk("wd ignored", seen, 0);

    // Reset during SHIFT drops the job
    @(negedge clk);
    x0 = 6'd13; y0 = 6'd11; req0 = 1'b1;
    @(negedge clk);
    chk("rm ack0", ack0, 1);
    req0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("rm busy pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rm busy", busy, 0);
    chk("rm prod", prod, 0);
    chk("rm bit_cnt", bit_cnt, 0);
    chk("rm hs", {ack0, ack1, done0, done1}, 0);
    seen = 1'b0;
    repeat (2) begin @(negedge clk); seen = seen | done0; end
    rst_n = 1'b1;
    repeat (10) begin @(negedge clk); seen = seen | done0 | busy; end
    chk("rm no done", seen, 0);
    job(0, 6'd2, 6'd3, 12'd6, "post rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
